time_travel_sequencer: RTL and testbench



---
 rtl/time_travel_sequencer.sv | 164 ++++++++++++++++
 tb/tb_time_travel_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/time_travel_sequencer.sv
// time_travel_sequencer
//   Accepts a signed target year over a valid/ready handshake. It latches the
//   signed difference and direction against the current-year register. It then
//   steps the current year toward the target by a programmable stride, one step
//   per cycle, and pulses done on arrival.
//
//   Optional feature macro: TT_BOUNDS_EN. When it is defined, a target outside
//   [MIN_YEAR, MAX_YEAR] is rejected with a one-cycle err pulse.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   req_valid  target request valid
//   req_ready  high only in IDLE
//   req_year   signed target year, sampled on accept
//   req_step   unsigned stride, sampled on accept; 0 acts as 1
//   abort      stop an in-progress travel (honoured in TRAVEL only)
//   cur_year   signed current year register
//   diff       signed target - cur_year at accept, W+1 bits
//   travel     {later, same, earlier}, one-hot
//   state_next {go, neg}
//   busy       high in CALC and TRAVEL
//   done       one-cycle pulse on arrival
//   err        one-cycle pulse on rejected target
module time_travel_sequencer #(
  parameter int unsigned W         = 12,
  parameter int          HOME_YEAR = 2019,
  parameter int unsigned SW        = 8,
  parameter int          MIN_YEAR  = 0,
  parameter int          MAX_YEAR  = 2047
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic signed [W-1:0] req_year,
  input  logic        [SW-1:0] req_step,
  input  logic                abort,
  output logic signed [W-1:0] cur_year,
  output logic signed [W:0]   diff,
  output logic        [2:0]   travel,
  output logic        [1:0]   state_next,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic signed [W-1:0] HomeYear = W'(HOME_YEAR);
  // Common width for comparing the remaining distance against the stride.
  localparam int unsigned CW = (W + 1 > SW) ? W + 1 : SW;

  typedef enum logic [1:0] {StIdle, StCalc, StTravel, StArrive} state_e;

  state_e              state_q;
  logic signed [W-1:0] tgt_q;
  logic       [SW-1:0] stp_q;
  logic signed [W-1:0] cur_year_q;
  logic signed [W:0]   diff_q;
  logic        [2:0]   travel_q;
  logic        [1:0]   state_next_q;
  logic                done_q;
  logic                err_q;

  // Difference in W+1 bits so that no pair of W-bit years can overflow.
  logic signed [W:0] tgt_x, cur_x, delta;
  logic        [W:0] rem;
  logic     [CW-1:0] rem_c, stp_c;
  logic              last_step;
  logic      [W-1:0] stride, cur_step;
  logic              same, earlier, later;
  logic              out_of_range;

  always_comb begin
    tgt_x     = {tgt_q[W-1], tgt_q};
    cur_x     = {cur_year_q[W-1], cur_year_q};
    delta     = tgt_x - cur_x;
    rem       = delta[W] ? $unsigned(-delta) : $unsigned(delta);
    rem_c     = CW'(rem);
    stp_c     = CW'(stp_q);
    // The final step is clipped to land exactly on the target.
    last_step = (rem_c <= stp_c);
    // Not a last step, so stride < rem < 2**W and the truncation is exact.
    stride    = stp_c[W-1:0];
    cur_step  = travel_q[2] ? ($unsigned(cur_year_q) + stride)
                            : ($unsigned(cur_year_q) - stride);
    earlier   = delta[W];
    same      = (delta == '0);
    later     = !earlier && !same;
  end

`ifdef TT_BOUNDS_EN
  localparam logic signed [W-1:0] MinYear = W'(MIN_YEAR);
  localparam logic signed [W-1:0] MaxYear = W'(MAX_YEAR);
  assign out_of_range = (tgt_q < MinYear) || (tgt_q > MaxYear);
`else
  // No bounds check in this build; every representable target is legal.
  assign out_of_range = 1'b0 && (MIN_YEAR <= MAX_YEAR);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tgt_q        <= '0;
      stp_q        <= '0;
      cur_year_q   <= HomeYear;
      diff_q       <= '0;
      travel_q     <= 3'b000;
      state_next_q <= 2'b00;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            tgt_q   <= req_year;
            stp_q   <= (req_step == '0) ? SW'(1) : req_step;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          if (out_of_range) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else begin
            diff_q       <= delta;
            travel_q     <= {later, same, earlier};
            state_next_q <= {!same, tgt_q[W-1]};
            if (same) begin
              done_q  <= 1'b1;
              state_q <= StArrive;
            end else begin
              state_q <= StTravel;
            end
          end
        end
        StTravel: begin
          // Arrival takes priority over a coincident abort.
          if (last_step) begin
            cur_year_q <= tgt_q;
            done_q     <= 1'b1;
            state_q    <= StArrive;
          end else begin
            cur_year_q <= cur_step;
            if (abort) state_q <= StIdle;
          end
        end
        StArrive: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign busy       = (state_q == StCalc) || (state_q == StTravel);
  assign cur_year   = cur_year_q;
  assign diff       = diff_q;
  assign travel     = travel_q;
  assign state_next = state_next_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_time_travel_sequencer.sv
module tb_time_travel_sequencer;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic signed [11:0] req_year;
  logic        [7:0]  req_step;
  logic               abort;
  logic signed [11:0] cur_year;
  logic signed [12:0] diff;
  logic        [2:0]  travel;
  logic        [1:0]  state_next;
  logic               busy;
  logic               done;
  logic               err;

  int total = 0;
  int bad   = 0;
  int err_cnt = 0;
  int n;

  time_travel_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_year   (req_year),
    .req_step   (req_step),
    .abort      (abort),
    .cur_year   (cur_year),
    .diff       (diff),
    .travel     (travel),
    .state_next (state_next),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (err === 1'b1) err_cnt++;
  endtask

  // Accept edge E0, then the CALC edge E1; returns just after E1.
  task automatic accept(input logic signed [11:0] y, input logic [7:0] s);
    check("ready_before_accept", 32'(req_ready), 1);
    req_year  = y;
    req_step  = s;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("calc_busy", 32'(busy), 1);
    check("calc_not_ready", 32'(req_ready), 0);
    tick();
  endtask

  // Count edges after E1 until done is seen, bounded.
  task automatic run_to_done(output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < 600) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_year = '0; req_step = '0; abort = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("rst_cur_year", 32'(cur_year), 2019);
    check("rst_ready", 32'(req_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_travel", 32'(travel), 0);
    check("rst_diff", 32'(diff), 0);
    check("rst_state_next", 32'(state_next), 0);

    // 2019 -> 1891, stride 16: 8 steps.
    accept(12'sd1891, 8'd16);
    check("a_diff", 32'(diff), -128);
    check("a_travel", 32'(travel), 3'b001);
    check("a_state_next", 32'(state_next), 2'b10);
    check("a_cur_unmoved", 32'(cur_year), 2019);
    tick();
    check("a_first_step", 32'(cur_year), 2003);
    run_to_done(n);
    check("a_edges", n + 1, 8);
    check("a_done", 32'(done), 1);
    check("a_cur", 32'(cur_year), 1891);
    tick();
    check("a_done_pulse", 32'(done), 0);
    check("a_ready", 32'(req_ready), 1);

    // 1891 -> 2019 via reset-free path is not wanted; reset back to home.
    rst_n = 1'b0; tick(); rst_n = 1'b1;

    // 2019 -> 2024, stride 0 acts as 1.
    accept(12'sd2024, 8'd0);
    check("b_diff", 32'(diff), 5);
    check("b_travel", 32'(travel), 3'b100);
    check("b_state_next", 32'(state_next), 2'b10);
    run_to_done(n);
    check("b_edges", n, 5);
    check("b_cur", 32'(cur_year), 2024);
    tick();

    // 2024 -> 2019, stride 100: one clipped step. Abort held throughout is
    // ignored in IDLE/CALC and loses to the arriving final step.
    abort = 1'b1;
    accept(12'sd2019, 8'd100);
    check("c_diff", 32'(diff), -5);
    check("c_travel", 32'(travel), 3'b001);
    run_to_done(n);
    check("c_edges", n, 1);
    check("c_done", 32'(done), 1);
    check("c_cur", 32'(cur_year), 2019);
    abort = 1'b0;
    tick();

    // Same year: no TRAVEL cycles.
    accept(12'sd2019, 8'd5);
    check("d_travel", 32'(travel), 3'b010);
    check("d_state_next", 32'(state_next), 2'b00);
    check("d_diff", 32'(diff), 0);
    check("d_done_now", 32'(done), 1);
    check("d_busy", 32'(busy), 0);
    tick();
    check("d_done_pulse", 32'(done), 0);

    // -100, stride 64, abort on the 2nd TRAVEL edge.
    accept(-12'sd100, 8'd64);
    check("e_diff", 32'(diff), -2119);
    check("e_state_next", 32'(state_next), 2'b11);
    check("e_travel", 32'(travel), 3'b001);
    tick();
    check("e_step1", 32'(cur_year), 1955);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("e_abort_cur", 32'(cur_year), 1891);
    check("e_abort_ready", 32'(req_ready), 1);
    check("e_abort_done", 32'(done), 0);
    tick(); tick();
    check("e_abort_no_done", 32'(done), 0);
    check("e_abort_hold", 32'(cur_year), 1891);

    // Reset in the middle of a long travel.
    accept(12'sd1500, 8'd1);
    tick(); tick(); tick();
    check("f_mid_cur", 32'(cur_year), 1888);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("f_rst_cur", 32'(cur_year), 2019);
    check("f_rst_diff", 32'(diff), 0);
    check("f_rst_travel", 32'(travel), 0);
    check("f_rst_state_next", 32'(state_next), 0);
    check("f_rst_busy", 32'(busy), 0);
    check("f_rst_done", 32'(done), 0);
    check("f_rst_ready", 32'(req_ready), 1);

    // Target -5 from 2019, stride 255.
    accept(-12'sd5, 8'd255);
`ifdef TT_BOUNDS_EN
    check("g_err", 32'(err), 1);
    check("g_cur", 32'(cur_year), 2019);
    check("g_diff", 32'(diff), 0);
    check("g_travel", 32'(travel), 0);
    check("g_done", 32'(done), 0);
    tick();
    check("g_err_pulse", 32'(err), 0);
    check("g_ready", 32'(req_ready), 1);
    check("g_err_count", err_cnt, 1);
`else
    check("g_diff", 32'(diff), -2024);
    check("g_state_next", 32'(state_next), 2'b11);
    run_to_done(n);
    check("g_edges", n, 8);
    check("g_cur", 32'(cur_year), -5);
    tick();
    check("g_err_count", err_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
